// File: rtl/adc_responder.sv
// adc_responder: SPI stand-in for the 8-channel 12-bit serial ADC.
// Each 16-clock frame shifts out 4 zeros and then 12 data bits, MSB first.
// The data belongs to the channel addressed in the previous frame.
// Samples come from ch_data, or from per-channel ramp counters when test_mode is set.
module adc_responder #(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic                     cs,
  input  logic                     din,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     test_mode,
  output logic                     dout,
  output logic                     frame_done,
  output logic [2:0]               last_addr
);

  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned IDX_W      = $clog2(DATA_W);
  localparam int unsigned SLOT_ADDR2 = 2;
  localparam int unsigned SLOT_LOAD  = 3;
  localparam int unsigned SLOT_ADDR0 = 4;
  localparam int unsigned SLOT_DATA0 = 4;
  localparam int unsigned SLOT_LAST  = 15;

  logic [CNT_W-1:0]  r_bit_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_cur_ch;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_ramp [NUM_CH];
  logic              r_dout;
  logic              r_frame_done;

  logic [DATA_W-1:0] w_sample;
  logic [IDX_W-1:0]  w_bit_idx;

  // Sample for the channel being converted; addresses beyond NUM_CH read as 0.
  always_comb begin
    w_sample = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (r_cur_ch == ADDR_W'(i)) begin
        w_sample = test_mode ? r_ramp[i] : ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Bit of the shift register presented in the current data slot (slot 4 -> MSB).
  always_comb begin
    w_bit_idx = IDX_W'(DATA_W + SLOT_DATA0 - 1) - IDX_W'(r_bit_cnt);
  end

  // Frame slot counter, address capture, sample load and frame completion.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt    <= '0;
      r_addr       <= '0;
      r_cur_ch     <= '0;
      r_last_addr  <= '0;
      r_shift      <= '0;
      r_frame_done <= 1'b0;
    end else if (cs) begin
      r_bit_cnt    <= '0;
      r_cur_ch     <= '0;
      r_addr       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_bit_cnt)
        CNT_W'(SLOT_ADDR2): r_addr[2] <= din;
        CNT_W'(SLOT_LOAD):  r_addr[1] <= din;
        CNT_W'(SLOT_ADDR0): r_addr[0] <= din;
        default: ;
      endcase
      if (r_bit_cnt == CNT_W'(SLOT_LOAD)) begin
        r_shift <= w_sample;
      end
      if (r_bit_cnt == CNT_W'(SLOT_LAST)) begin
        r_bit_cnt    <= '0;
        r_cur_ch     <= r_addr;
        r_last_addr  <= r_addr;
        r_frame_done <= 1'b1;
      end else begin
        r_bit_cnt    <= r_bit_cnt + CNT_W'(1);
        r_frame_done <= 1'b0;
      end
    end
  end

  // Ramp counters advance when their channel is converted in test mode.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_ramp[i] <= '0;
      end
    end else if (!cs && test_mode && (r_bit_cnt == CNT_W'(SLOT_LOAD))) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (r_cur_ch == ADDR_W'(i)) begin
          r_ramp[i] <= r_ramp[i] + DATA_W'(RAMP_STEP);
        end
      end
    end
  end

  // Serial data changes on the falling edge so it is stable at the controller's rising edge.
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= 1'b0;
    end else if (!cs && (r_bit_cnt >= CNT_W'(SLOT_DATA0))) begin
      r_dout <= r_shift[w_bit_idx];
    end else begin
      r_dout <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign frame_done = r_frame_done;
  assign last_addr  = r_last_addr;

endmodule

// File: tb/tb_adc_responder.sv
// Directed self-checking bench for adc_responder.
`timescale 1ns/1ps
module tb_adc_responder;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned DATA_W = 12;

  logic                     sclk = 1'b0;
  logic                     rst_n;
  logic                     cs;
  logic                     din;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     test_mode;
  logic                     dout;
  logic                     frame_done;
  logic [2:0]               last_addr;

  int total = 0;
  int bad   = 0;

  logic [2:0]  seq [7] = '{3'd2, 3'd7, 3'd5, 3'd2, 3'd7, 3'd5, 3'd2};
  logic [15:0] w;
  logic [15:0] prev;
  logic        q;
  logic        ok;

  always #5 sclk = ~sclk;

  adc_responder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RAMP_STEP(1)) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .cs         (cs),
    .din        (din),
    .ch_data    (ch_data),
    .test_mode  (test_mode),
    .dout       (dout),
    .frame_done (frame_done),
    .last_addr  (last_addr)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [11:0] v);
    ch_data[ch*DATA_W +: DATA_W] = v;
  endtask

  function automatic logic [11:0] get_ch(input logic [2:0] ch);
    return ch_data[int'(ch)*DATA_W +: DATA_W];
  endfunction

  function automatic logic addr_bit(input logic [2:0] a, input int k);
    if (k == 2) return a[2];
    if (k == 3) return a[1];
    if (k == 4) return a[0];
    return 1'b0;
  endfunction

  // One slot: drive din, read dout after the falling edge, end just after the rising edge.
  task automatic slot(input logic d, output logic qo);
    din = d;
    @(negedge sclk); #1;
    qo = dout;
    @(posedge sclk); #1;
  endtask

  task automatic frame(input logic [2:0] a, output logic [15:0] wd);
    logic qq;
    cs = 1'b0;
    for (int k = 0; k < 16; k++) begin
      slot(addr_bit(a, k), qq);
      wd[15-k] = qq;
    end
  endtask

  task automatic idle(input int n);
    cs  = 1'b1;
    din = 1'b0;
    repeat (n) begin
      @(posedge sclk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b1; din = 1'b0; test_mode = 1'b0; ch_data = '0;
    #1;
    check("rst_dout", 16'(dout), 16'h0);
    check("rst_frame_done", 16'(frame_done), 16'h0);
    check("rst_last_addr", 16'(last_addr), 16'h0);
    @(posedge sclk); #1;
    rst_n = 1'b1;
    idle(2);

    // Basic two-frame exchange
    set_ch(0, 12'hABC);
    set_ch(2, 12'h5A3);
    frame(3'd2, w);
    check("t1_frame1_word", w, 16'h0ABC);
    check("t1_frame1_done", 16'(frame_done), 16'h1);
    check("t1_last_addr", 16'(last_addr), 16'h2);
    frame(3'd0, w);
    check("t1_frame2_word", w, 16'h05A3);
    check("t1_frame2_done", 16'(frame_done), 16'h1);
    idle(1);
    check("t1_done_clears", 16'(frame_done), 16'h0);

    // Cyclic addresses, back-to-back frames
    set_ch(2, 12'h123);
    set_ch(7, 12'hFED);
    set_ch(5, 12'h800);
    idle(2);
    prev = 16'h0ABC;
    for (int i = 0; i < 7; i++) begin
      frame(seq[i], w);
      check($sformatf("t2_word%0d", i), w, prev);
      prev = {4'h0, get_ch(seq[i])};
    end

    // Ramp mode on channel 3, through the wrap
    idle(2);
    test_mode = 1'b0;
    frame(3'd3, w);
    check("t3_first_ch0", w, 16'h0ABC);
    test_mode = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      frame(3'd3, w);
      if (w !== 16'(k)) ok = 1'b0;
      if (k < 3 || k == 4095) check($sformatf("t3_ramp%0d", k), w, 16'(k));
    end
    check("t3_ramp_sequence", 16'(ok), 16'h1);
    frame(3'd5, w);
    check("t3_wrap", w, 16'h0000);
    frame(3'd0, w);
    check("t3_ch5_untouched", w, 16'h0000);
    frame(3'd0, w);
    check("t3_ch0_untouched", w, 16'h0000);

    // Abort at slot 9 of a frame addressing 6
    test_mode = 1'b0;
    idle(2);
    set_ch(1, 12'h111);
    set_ch(6, 12'h666);
    frame(3'd1, w);
    check("t4_pre_word", w, 16'h0ABC);
    check("t4_pre_last_addr", 16'(last_addr), 16'h1);
    cs = 1'b0;
    for (int k = 0; k < 9; k++) slot(addr_bit(3'd6, k), q);
    cs = 1'b1;
    @(negedge sclk); #1;
    check("t4_abort_dout", 16'(dout), 16'h0);
    @(posedge sclk); #1;
    check("t4_abort_no_done", 16'(frame_done), 16'h0);
    check("t4_abort_last_addr", 16'(last_addr), 16'h1);
    frame(3'd0, w);
    check("t4_restart_ch0", w, 16'h0ABC);
    check("t4_restart_done", 16'(frame_done), 16'h1);

    // Asynchronous reset mid-frame
    idle(2);
    set_ch(0, 12'h321);
    set_ch(4, 12'hFFF);
    frame(3'd4, w);
    check("t5_pre_word", w, 16'h0321);
    cs = 1'b0;
    for (int k = 0; k < 7; k++) slot(addr_bit(3'd0, k), q);
    @(negedge sclk); #1;
    check("t5_dout_high", 16'(dout), 16'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_dout", 16'(dout), 16'h0);
    check("t5_rst_last_addr", 16'(last_addr), 16'h0);
    check("t5_rst_bit_cnt", 16'(dut.r_bit_cnt), 16'h0);
    @(posedge sclk); #1;
    rst_n = 1'b1;
    idle(1);
    frame(3'd2, w);
    check("t5_after_word", w, 16'h0321);
    check("t5_after_last_addr", 16'(last_addr), 16'h2);
    idle(2);
    test_mode = 1'b1;
    frame(3'd0, w);
    check("t5_ramp_cleared", w, 16'h0000);
    test_mode = 1'b0;

    // ch_data changes after the slot-3 load
    idle(2);
    set_ch(0, 12'h0F0);
    cs = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) set_ch(0, 12'hFFF);
      slot(addr_bit(3'd0, k), q);
      w[15-k] = q;
    end
    check("t6_old_value", w, 16'h00F0);
    frame(3'd0, w);
    check("t6_new_value", w, 16'h0FFF);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
